// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a req/gnt/rvalid data bus, one access in flight.
// Ports: EX/MEM inputs mem_*_i, stall vector stalled_i, stall request stallreq_o,
// write-back triple wb_*_o, data bus dbus_*, status flags misalign_o and timeout_o.
`ifndef MEM_LSU_ALUOPS
`define MEM_LSU_ALUOPS
`define AluOpBus 7:0
`define EXE_NONE 8'b00000000
`define EXE_ADD  8'b00100000
`define EXE_LB   8'b11100000
`define EXE_LH   8'b11100001
`define EXE_LW   8'b11100011
`define EXE_LBU  8'b11100100
`define EXE_LHU  8'b11100101
`define EXE_SB   8'b11101000
`define EXE_SH   8'b11101001
`define EXE_SW   8'b11101011
`endif
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_wreg_i,
  input  logic [4:0]        mem_wreg_addr_i,
  input  logic [31:0]       mem_wreg_data_i,
  input  logic [`AluOpBus]  mem_aluop_i,
  input  logic [31:0]       mem_memaddr_i,
  input  logic [31:0]       mem_operand2_i,
  input  logic [4:0]        stalled_i,
  output logic              stallreq_o,
  output logic              wb_wreg_o,
  output logic [4:0]        wb_wreg_addr_o,
  output logic [31:0]       wb_wreg_data_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [31:0]       dbus_addr_o,
  output logic [3:0]        dbus_be_o,
  output logic [31:0]       dbus_wdata_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [31:0]       dbus_rdata_i,
  output logic              misalign_o,
  output logic              timeout_o
);
  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP, DONE} state_t;
  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        to_q;
  logic        is_load, is_store, is_mem, is_half, is_word, misal, go, tmo, done, busy, unused_stall;
  logic [1:0]  lane;
  logic [15:0] half;
  logic [7:0]  byte_sel;
  logic [31:0] ld_data;
  assign lane      = mem_memaddr_i[1:0];
  assign is_load   = mem_aluop_i inside {`EXE_LB, `EXE_LBU, `EXE_LH, `EXE_LHU, `EXE_LW};
  assign is_store  = mem_aluop_i inside {`EXE_SB, `EXE_SH, `EXE_SW};
  assign is_mem    = is_load | is_store;
  assign is_half   = mem_aluop_i inside {`EXE_LH, `EXE_LHU, `EXE_SH};
  assign is_word   = mem_aluop_i inside {`EXE_LW, `EXE_SW};
  assign misal     = (is_half & lane[0]) | (is_word & |lane);
  assign go        = is_mem & ~misal;
  // >= rather than ==: a grant on the last allowed cycle pushes the counter past the limit
  assign tmo       = cnt_q >= 8'(TIMEOUT_CYCLES - 1);
  assign done      = state_q == DONE;
  assign busy      = state_q == WAIT_GNT || state_q == WAIT_RSP;
  assign unused_stall = ^stalled_i[3:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          to_q  <= 1'b0;
          cnt_q <= '0;
          if (go) state_q <= dbus_gnt_i ? WAIT_RSP : WAIT_GNT;
        end
        WAIT_GNT: begin
          cnt_q <= cnt_q + 8'd1;
          if (dbus_gnt_i) state_q <= WAIT_RSP;
          else if (tmo) begin
            state_q <= DONE;
            to_q    <= 1'b1;
          end
        end
        WAIT_RSP: begin
          cnt_q <= cnt_q + 8'd1;
          if (dbus_rvalid_i) begin
            rdata_q <= dbus_rdata_i;
            state_q <= DONE;
          end else if (tmo) begin
            state_q <= DONE;
            to_q    <= 1'b1;
          end
        end
        default: if (!stalled_i[4]) state_q <= IDLE;
      endcase
    end
  end
  always_comb begin
    half     = lane[1] ? rdata_q[31:16] : rdata_q[15:0];
    byte_sel = lane[0] ? half[15:8] : half[7:0];
    ld_data  = mem_aluop_i == `EXE_LB  ? {{24{byte_sel[7]}}, byte_sel} :
               mem_aluop_i == `EXE_LBU ? {24'b0, byte_sel} :
               mem_aluop_i == `EXE_LH  ? {{16{half[15]}}, half} :
               mem_aluop_i == `EXE_LHU ? {16'b0, half} : rdata_q;
  end
  // rst_n gating keeps the request low the instant reset asserts, even if EX/MEM still shows an op
  assign dbus_req_o     = rst_n & ((state_q == IDLE & go) | state_q == WAIT_GNT);
  assign stallreq_o     = rst_n & ((state_q == IDLE & go) | busy);
  assign misalign_o     = rst_n & is_mem & misal;
  assign timeout_o      = done & to_q;
  assign dbus_we_o      = is_store;
  assign dbus_addr_o    = {mem_memaddr_i[31:2], 2'b00};
  assign dbus_be_o      = mem_aluop_i == `EXE_SB ? 4'b0001 << lane :
                          mem_aluop_i == `EXE_SH ? (lane[1] ? 4'b1100 : 4'b0011) :
                          is_mem ? 4'b1111 : 4'b0000;
  assign dbus_wdata_o   = mem_aluop_i == `EXE_SB ? {4{mem_operand2_i[7:0]}} :
                          mem_aluop_i == `EXE_SH ? {2{mem_operand2_i[15:0]}} : mem_operand2_i;
  assign wb_wreg_o      = is_mem ? (done & is_load & ~to_q & mem_wreg_i) : mem_wreg_i;
  assign wb_wreg_addr_o = mem_wreg_addr_i;
  assign wb_wreg_data_o = (done & is_load) ? ld_data : mem_wreg_data_i;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu against a transaction-level model.
`ifndef MEM_LSU_ALUOPS
`define MEM_LSU_ALUOPS
`define AluOpBus 7:0
`define EXE_NONE 8'b00000000
`define EXE_ADD  8'b00100000
`define EXE_LB   8'b11100000
`define EXE_LH   8'b11100001
`define EXE_LW   8'b11100011
`define EXE_LBU  8'b11100100
`define EXE_LHU  8'b11100101
`define EXE_SB   8'b11101000
`define EXE_SH   8'b11101001
`define EXE_SW   8'b11101011
`endif
module tb_mem_lsu;
  localparam int T = 8;
  logic clk = 0, rst_n = 0;
  logic mem_wreg_i = 0;
  logic [4:0] mem_wreg_addr_i = 0;
  logic [31:0] mem_wreg_data_i = 0, mem_memaddr_i = 0, mem_operand2_i = 0, dbus_rdata_i = 0;
  logic [`AluOpBus] mem_aluop_i = `EXE_NONE;
  logic [4:0] stalled_i = 0;
  logic dbus_gnt_i = 0, dbus_rvalid_i = 0;
  logic stallreq_o, wb_wreg_o, dbus_req_o, dbus_we_o, misalign_o, timeout_o;
  logic [4:0] wb_wreg_addr_o;
  logic [31:0] wb_wreg_data_o, dbus_addr_o, dbus_wdata_o;
  logic [3:0] dbus_be_o;
  mem_lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .mem_wreg_i(mem_wreg_i), .mem_wreg_addr_i(mem_wreg_addr_i),
    .mem_wreg_data_i(mem_wreg_data_i), .mem_aluop_i(mem_aluop_i), .mem_memaddr_i(mem_memaddr_i),
    .mem_operand2_i(mem_operand2_i), .stalled_i(stalled_i), .stallreq_o(stallreq_o),
    .wb_wreg_o(wb_wreg_o), .wb_wreg_addr_o(wb_wreg_addr_o), .wb_wreg_data_o(wb_wreg_data_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i(dbus_rdata_i), .misalign_o(misalign_o), .timeout_o(timeout_o)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  bit chk_en = 0, chk_wb = 0, chk_wbd = 0;
  logic exp_stall, exp_req, exp_mis, exp_to, exp_we, exp_wreg;
  logic [3:0] exp_be;
  logic [4:0] exp_waddr;
  logic [31:0] exp_addr, exp_wd, exp_wbdata;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic int m_size(input logic [7:0] op);
    case (op)
      `EXE_LB, `EXE_LBU, `EXE_SB: return 1;
      `EXE_LH, `EXE_LHU, `EXE_SH: return 2;
      `EXE_LW, `EXE_SW: return 4;
      default: return 0;
    endcase
  endfunction
  function automatic bit m_isload(input logic [7:0] op);
    return op inside {`EXE_LB, `EXE_LBU, `EXE_LH, `EXE_LHU, `EXE_LW};
  endfunction
  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
    int unsigned b, h;
    b = (rd >> (8 * (a % 4))) & 32'hff;
    h = (rd >> (16 * ((a % 4) / 2))) & 32'hffff;
    case (op)
      `EXE_LB:  return b >= 128 ? b - 256 : b;
      `EXE_LBU: return b;
      `EXE_LH:  return h >= 32768 ? h - 65536 : h;
      `EXE_LHU: return h;
      default:  return rd;
    endcase
  endfunction
  function automatic logic [3:0] m_be(input logic [7:0] op, input logic [31:0] a);
    if (m_size(op) == 0) return 4'h0;
    if (m_isload(op) || m_size(op) == 4) return 4'hf;
    return m_size(op) == 1 ? 4'(1 << (a % 4)) : 4'(3 << (a % 4));
  endfunction
  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] d);
    case (op)
      `EXE_SB: return d[7:0] * 32'h01010101;
      `EXE_SH: return d[15:0] * 32'h00010001;
      default: return d;
    endcase
  endfunction
  always @(negedge clk) if (chk_en) begin
    chk("stallreq", stallreq_o, exp_stall);
    chk("req", dbus_req_o, exp_req);
    chk("misalign", misalign_o, exp_mis);
    chk("timeout", timeout_o, exp_to);
    if (exp_req) begin
      chk("addr", dbus_addr_o, exp_addr);
      chk("be", dbus_be_o, exp_be);
      chk("we", dbus_we_o, exp_we);
      chk("wdata", dbus_wdata_o, exp_wd);
    end
    if (chk_wb) begin
      chk("wb_wreg", wb_wreg_o, exp_wreg);
      chk("wb_addr", wb_wreg_addr_o, exp_waddr);
    end
    if (chk_wbd) chk("wb_data", wb_wreg_data_o, exp_wbdata);
  end
  // g: cycle of grant (0 = same cycle as request), r: cycles from grant to rvalid,
  // hold: DONE cycles with stalled_i[4] set; lit_en pins the write-back data to a literal
  task automatic run_op(input logic [7:0] op, input logic wreg, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic [31:0] addr, input logic [31:0] op2,
                        input int g, input int r, input logic [31:0] rd, input int hold,
                        input bit lit_en, input logic [31:0] lit);
    int sz, d, ct;
    bit to, ld, dn;
    mem_aluop_i = op; mem_wreg_i = wreg; mem_wreg_addr_i = waddr; mem_wreg_data_i = wdata;
    mem_memaddr_i = addr; mem_operand2_i = op2;
    sz = m_size(op); ld = m_isload(op);
    exp_addr = {addr[31:2], 2'b00}; exp_be = m_be(op, addr); exp_we = (sz != 0) && !ld;
    exp_wd = m_wdata(op, op2); exp_waddr = waddr; exp_wbdata = wdata;
    if (sz == 0 || addr % sz != 0) begin
      exp_stall = 0; exp_req = 0; exp_mis = sz != 0; exp_to = 0;
      chk_wb = 1; chk_wbd = sz == 0; exp_wreg = sz == 0 ? wreg : 1'b0;
      @(posedge clk); #1;
      return;
    end
    ct = (g + 1 > T) ? g + 1 : T;
    if (g > T) begin to = 1; d = T + 1; end
    else if (g + r <= ct) begin to = 0; d = g + r + 1; end
    else begin to = 1; d = ct + 1; end
    for (int c = 0; c <= d + hold; c++) begin
      dn = c >= d;
      dbus_gnt_i = (c == g) || (dn && c == d);
      dbus_rvalid_i = (c == g + r) || (dn && c == d);
      dbus_rdata_i = dn ? 32'hFFFF_FFFF : rd;
      stalled_i = (dn && c < d + hold) ? 5'h10 : 5'h00;
      exp_stall = !dn; exp_req = !dn && c <= g; exp_mis = 0; exp_to = dn && to;
      chk_wb = dn; chk_wbd = dn && ld && !to; exp_wreg = dn && ld && !to && wreg;
      exp_wbdata = m_load(op, addr, rd);
      if (lit_en && c == d) chk("lit_wb_data", wb_wreg_data_o, lit);
      @(posedge clk); #1;
    end
    dbus_gnt_i = 0; dbus_rvalid_i = 0; stalled_i = 0;
  endtask
  initial begin
    #12;
    chk("rst_stallreq", stallreq_o, 0);
    chk("rst_req", dbus_req_o, 0);
    chk("rst_misalign", misalign_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_wb_wreg", wb_wreg_o, 0);
    chk("rst_wb_data", wb_wreg_data_o, 0);
    chk("rst_be", dbus_be_o, 0);
    exp_stall = 0; exp_req = 0; exp_mis = 0; exp_to = 0; exp_wreg = 0; exp_waddr = 0;
    exp_wbdata = 0; chk_wb = 1; chk_wbd = 1; chk_en = 1;
    rst_n = 1;
    @(posedge clk); #1;
    run_op(`EXE_LW, 1, 5'd3, 0, 32'h100, 0, 0, 2, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF);
    run_op(`EXE_LB, 1, 5'd4, 0, 32'h103, 0, 1, 1, 32'h80112233, 0, 1, 32'hFFFFFF80);
    run_op(`EXE_LBU, 1, 5'd4, 0, 32'h103, 0, 0, 1, 32'h80112233, 0, 1, 32'h00000080);
    run_op(`EXE_LH, 1, 5'd5, 0, 32'h102, 0, 2, 1, 32'h80112233, 0, 1, 32'hFFFF8011);
    run_op(`EXE_LHU, 1, 5'd6, 0, 32'h100, 0, 0, 3, 32'h80112233, 0, 1, 32'h00002233);
    mem_aluop_i = `EXE_SH; mem_memaddr_i = 32'h202; mem_operand2_i = 32'h1234ABCD; #1;
    chk("sh_addr", dbus_addr_o, 32'h200);
    chk("sh_be", dbus_be_o, 4'b1100);
    chk("sh_wdata", dbus_wdata_o, 32'hABCDABCD);
    chk("sh_we", dbus_we_o, 1);
    run_op(`EXE_SH, 1, 5'd7, 32'h55, 32'h202, 32'h1234ABCD, 1, 1, 0, 0, 0, 0);
    run_op(`EXE_SB, 0, 5'd0, 0, 32'h201, 32'h00000077, 0, 1, 0, 0, 0, 0);
    run_op(`EXE_SW, 0, 5'd0, 0, 32'h204, 32'hCAFEF00D, 2, 2, 0, 0, 0, 0);
    mem_aluop_i = `EXE_LW; mem_memaddr_i = 32'h101; mem_wreg_i = 1; #1;
    chk("mis_flag", misalign_o, 1);
    chk("mis_req", dbus_req_o, 0);
    chk("mis_wreg", wb_wreg_o, 0);
    run_op(`EXE_LW, 1, 5'd8, 0, 32'h101, 0, 0, 1, 0, 0, 0, 0);
    run_op(`EXE_SH, 0, 5'd0, 0, 32'h203, 0, 0, 1, 0, 0, 0, 0);
    run_op(`EXE_LH, 1, 5'd9, 0, 32'h105, 0, 0, 1, 0, 0, 0, 0);
    run_op(`EXE_SW, 0, 5'd0, 0, 32'h106, 0, 0, 1, 0, 0, 0, 0);
    mem_aluop_i = `EXE_ADD; mem_wreg_i = 1; mem_wreg_addr_i = 5'd10; mem_wreg_data_i = 32'h12345678; #1;
    chk("add_data", wb_wreg_data_o, 32'h12345678);
    chk("add_stall", stallreq_o, 0);
    run_op(`EXE_ADD, 1, 5'd10, 32'h12345678, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    run_op(`EXE_LW, 1, 5'd11, 0, 32'h300, 0, 100, 1, 32'h1, 0, 0, 0);
    run_op(`EXE_LW, 1, 5'd11, 0, 32'h300, 0, 3, 10, 32'h2, 0, 0, 0);
    run_op(`EXE_LW, 1, 5'd11, 0, 32'h300, 0, 8, 1, 32'h3, 0, 1, 32'h3);
    run_op(`EXE_LW, 1, 5'd11, 0, 32'h300, 0, 8, 2, 32'h4, 0, 0, 0);
    run_op(`EXE_LW, 1, 5'd11, 0, 32'h300, 0, 2, 6, 32'h5, 0, 1, 32'h5);
    run_op(`EXE_LW, 1, 5'd11, 0, 32'h300, 0, 2, 7, 32'h6, 0, 0, 0);
    run_op(`EXE_LB, 1, 5'd12, 0, 32'h101, 0, 0, 1, 32'h0000FE00, 3, 1, 32'hFFFFFFFE);
    mem_aluop_i = `EXE_LW; mem_memaddr_i = 32'h400; mem_wreg_i = 1; mem_wreg_addr_i = 5'd13;
    dbus_gnt_i = 1; exp_stall = 1; exp_req = 1; exp_mis = 0; exp_to = 0; chk_wb = 0; chk_wbd = 0;
    exp_addr = 32'h400; exp_be = 4'hf; exp_we = 0;
    @(posedge clk); #1;
    dbus_gnt_i = 0; exp_req = 0;
    @(negedge clk); #2;
    rst_n = 0; #1;
    chk("rst_mid_req", dbus_req_o, 0);
    chk("rst_mid_stall", stallreq_o, 0);
    mem_aluop_i = `EXE_NONE; mem_memaddr_i = 0; mem_wreg_i = 0; mem_wreg_addr_i = 0; mem_wreg_data_i = 0;
    exp_stall = 0; exp_wreg = 0; exp_waddr = 0; exp_wbdata = 0; chk_wb = 1; chk_wbd = 1;
    @(posedge clk); #1;
    rst_n = 1; dbus_rvalid_i = 1; dbus_rdata_i = 32'hAAAA5555;
    @(posedge clk); #1;
    dbus_rvalid_i = 0;
    @(posedge clk); #1;
    run_op(`EXE_LW, 1, 5'd14, 0, 32'h404, 0, 0, 1, 32'h13579BDF, 0, 1, 32'h13579BDF);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
